fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 189 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, 2-entry {PC, Inst} queue and FETCH/DROP
// request control. Optional macro FETCH_PERF_EN adds the FetchCount push counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        StallF,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Inst_out,
    output logic [31:0] PC_out,
    output logic        Valid_out,
    output logic        Busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount
`endif
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_DROP  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] e0_q, e0_d;
    logic [63:0] e1_q, e1_d;
    logic        push_s;
    logic        pop_s;

    // Request and head-of-queue outputs derived from registered state
    always_comb begin
        ImemReq  = 1'b0;
        ImemAddr = pc_q;
        Busy     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ImemReq  = (cnt_q != 2'd2);
                ImemAddr = pc_q;
                Busy     = 1'b0;
            end
            S_DROP: begin
                // The abandoned request must stay on the bus until it is acknowledged
                ImemReq  = 1'b1;
                ImemAddr = drop_addr_q;
                Busy     = 1'b1;
            end
            default: begin
                ImemReq  = 1'b0;
                ImemAddr = pc_q;
                Busy     = 1'b0;
            end
        endcase
        Valid_out = (cnt_q != 2'd0);
        if (Valid_out) begin
            Inst_out = e0_q[31:0];
            PC_out   = e0_q[63:32];
        end else begin
            Inst_out = 32'h0000_0000;
            PC_out   = 32'h0000_0000;
        end
    end

    // Next-state logic: redirect overrides push, pop and stall
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        cnt_d       = cnt_q;
        e0_d        = e0_q;
        e1_d        = e1_q;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (Redirect) begin
                    cnt_d = 2'd0;
                    pc_d  = {RedirectPC[31:2], 2'b00};
                    if (ImemReq && !ImemAck) begin
                        state_d     = S_DROP;
                        drop_addr_d = pc_q;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    push_s = ImemReq && ImemAck;
                    pop_s  = (cnt_q != 2'd0) && !StallF;
                    if (push_s) begin
                        pc_d = pc_q + 32'd4;
                    end else begin
                        pc_d = pc_q;
                    end
                    case ({push_s, pop_s})
                        2'b10: begin
                            if (cnt_q == 2'd0) begin
                                e0_d  = {pc_q, ImemData};
                                cnt_d = 2'd1;
                            end else begin
                                e1_d  = {pc_q, ImemData};
                                cnt_d = 2'd2;
                            end
                        end
                        2'b01: begin
                            e0_d  = e1_q;
                            cnt_d = cnt_q - 2'd1;
                        end
                        2'b11: begin
                            // Only reachable at count 1: the new word replaces the head
                            e0_d  = {pc_q, ImemData};
                            cnt_d = 2'd1;
                        end
                        default: begin
                            cnt_d = cnt_q;
                        end
                    endcase
                end
            end
            S_DROP: begin
                cnt_d = 2'd0;
                if (Redirect) begin
                    pc_d = {RedirectPC[31:2], 2'b00};
                end else begin
                    pc_d = pc_q;
                end
                if (ImemAck) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_DROP;
                end
            end
            default: begin
                state_d = S_FETCH;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // State, PC and queue registers
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            drop_addr_q <= 32'h0000_0000;
            cnt_q       <= 2'd0;
            e0_q        <= 64'h0;
            e1_q        <= 64'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            cnt_q       <= cnt_d;
            e0_q        <= e0_d;
            e1_q        <= e1_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // Push counter, wraps naturally at 2^32
    always_comb begin
        if (push_s) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // Push counter register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            fetch_count_q <= 32'h0000_0000;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign FetchCount = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, mid-request reset,
// then randomized traffic compared against a queue-based reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        Reset;
    logic        StallF;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic [31:0] Inst_out;
    logic [31:0] PC_out;
    logic        Valid_out;
    logic        Busy;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .Reset(Reset), .StallF(StallF), .Redirect(Redirect),
        .RedirectPC(RedirectPC), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemAck(ImemAck), .ImemData(ImemData), .Inst_out(Inst_out),
        .PC_out(PC_out), .Valid_out(Valid_out), .Busy(Busy)
`ifdef FETCH_PERF_EN
        , .FetchCount(fetch_count)
`endif
    );

    // Reference model: queue of {pc, inst}, a fetch address and a discard flag
    logic [63:0] mq[$];
    logic [31:0] mpc;
    logic [31:0] mdrop_addr;
    bit          mdrop;
    logic [31:0] mcount;

    function automatic logic m_req();
        return mdrop || (mq.size() < 2);
    endfunction

    function automatic logic [31:0] m_addr();
        return mdrop ? mdrop_addr : mpc;
    endfunction

    task automatic model_reset();
        mq.delete();
        mpc = 32'h0000_0000;
        mdrop_addr = 32'h0000_0000;
        mdrop = 1'b0;
        mcount = 32'h0000_0000;
    endtask

    task automatic model_step();
        logic req;
        req = m_req();
        if (Redirect) begin
            if (mdrop) begin
                if (ImemAck) mdrop = 1'b0;
            end else if (req && !ImemAck) begin
                mdrop = 1'b1;
                mdrop_addr = mpc;
            end
            mq.delete();
            mpc = RedirectPC & 32'hFFFF_FFFC;
        end else if (mdrop) begin
            if (ImemAck) mdrop = 1'b0;
        end else begin
            if (mq.size() != 0 && !StallF) void'(mq.pop_front());
            if (req && ImemAck) begin
                mq.push_back({mpc, ImemData});
                mpc = mpc + 32'd4;
                mcount = mcount + 32'd1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [63:0] head;
        head = (mq.size() != 0) ? mq[0] : 64'h0;
        chk("rnd_req", {31'd0, ImemReq}, {31'd0, m_req()});
        chk("rnd_addr", ImemAddr, m_addr());
        chk("rnd_valid", {31'd0, Valid_out}, {31'd0, (mq.size() != 0)});
        chk("rnd_pc", PC_out, head[63:32]);
        chk("rnd_inst", Inst_out, head[31:0]);
        chk("rnd_busy", {31'd0, Busy}, {31'd0, mdrop});
`ifdef FETCH_PERF_EN
        chk("rnd_fetchcount", fetch_count, mcount);
`endif
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] data;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
        logic [31:0] einst;
        logic        ebusy;
    } vec_t;

    vec_t tbl[20];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0000, 1'b1, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0001, 1'b1, 32'h4,         1'b1, 32'h0,         32'hA000_0000, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h4,         32'hA000_0001, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'h103,       1'b0, 32'h0,         1'b1, 32'h8,         1'b0, 32'h0,         32'h0,         1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8,         1'b0, 32'h0,         32'h0,         1'b1};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1, 32'h8,         1'b0, 32'h0,         32'h0,         1'b1};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hB000_0000, 1'b1, 32'h100,       1'b0, 32'h0,         32'h0,         1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hB000_0001, 1'b1, 32'h104,       1'b1, 32'h100,       32'hB000_0000, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h108,       1'b1, 32'h100,       32'hB000_0000, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h108,       1'b1, 32'h100,       32'hB000_0000, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h108,       1'b1, 32'h104,       32'hB000_0001, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'h40,        1'b1, 32'hC000_0000, 1'b1, 32'h108,       1'b0, 32'h0,         32'h0,         1'b0};
        tbl[12] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 1'b1, 32'h40,        1'b0, 32'h0,         32'h0,         1'b0};
        tbl[13] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hD000_0000, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0,         1'b0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hD000_0001, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'hD000_0000, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0,         32'hD000_0001, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 32'h200,       1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0,         32'h0,         1'b0};
        tbl[17] = '{1'b0, 1'b1, 32'h300,       1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0,         32'h0,         1'b1};
        tbl[18] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hE000_0000, 1'b1, 32'h4,         1'b0, 32'h0,         32'h0,         1'b1};
        tbl[19] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h300,       1'b0, 32'h0,         32'h0,         1'b0};

        Reset = 1'b1;
        StallF = 1'b0;
        Redirect = 1'b0;
        RedirectPC = 32'h0;
        ImemAck = 1'b0;
        ImemData = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_valid", {31'd0, Valid_out}, 32'd0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_addr", ImemAddr, 32'h0);
        chk("reset_pc_out", PC_out, 32'h0);
        chk("reset_inst_out", Inst_out, 32'h0);
        Reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            StallF = tbl[i].stall;
            Redirect = tbl[i].redir;
            RedirectPC = tbl[i].rpc;
            ImemAck = tbl[i].ack;
            ImemData = tbl[i].data;
            #1;
            chk($sformatf("vec%0d_req", i), {31'd0, ImemReq}, {31'd0, tbl[i].ereq});
            chk($sformatf("vec%0d_addr", i), ImemAddr, tbl[i].eaddr);
            chk($sformatf("vec%0d_valid", i), {31'd0, Valid_out}, {31'd0, tbl[i].evalid});
            chk($sformatf("vec%0d_pc", i), PC_out, tbl[i].epc);
            chk($sformatf("vec%0d_inst", i), Inst_out, tbl[i].einst);
            chk($sformatf("vec%0d_busy", i), {31'd0, Busy}, {31'd0, tbl[i].ebusy});
            advance();
        end

        // Asynchronous reset while the request to 0x300 is outstanding
        StallF = 1'b0;
        Redirect = 1'b0;
        ImemAck = 1'b0;
`ifdef FETCH_PERF_EN
        chk("perf_before_reset", fetch_count, 32'd6);
`endif
        #2 Reset = 1'b1;
        #1;
        chk("async_addr", ImemAddr, 32'h0);
        chk("async_req", {31'd0, ImemReq}, 32'd1);
        chk("async_busy", {31'd0, Busy}, 32'd0);
        chk("async_valid", {31'd0, Valid_out}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("perf_async_reset", fetch_count, 32'd0);
`endif
        model_reset();
        @(negedge clk);
        Reset = 1'b0;

        for (int c = 0; c < 1500; c++) begin
            StallF = ($urandom_range(0, 2) == 0);
            Redirect = ($urandom_range(0, 9) == 0);
            RedirectPC = $urandom;
            ImemAck = m_req() && ($urandom_range(0, 1) == 1);
            ImemData = $urandom;
            #1;
            check_model();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
